// File: rtl/spasreg_pkg.sv
`default_nettype none
// ============================================================================
// Module : spasreg_pkg
// Brief  : Shared op encodings, width default and requester IDs for the
//          control-register write arbiter.
// Rev    : 1.0
// ============================================================================
package spasreg_pkg;

  localparam int SPASREG_WIDTH = 32;

  typedef enum logic [1:0] {
    SPASREG_OP_WRITE  = 2'b00,
    SPASREG_OP_SET    = 2'b01,
    SPASREG_OP_CLR    = 2'b10,
    SPASREG_OP_TOGGLE = 2'b11
  } spasreg_op_e;

  localparam logic SPASREG_HOST = 1'b0;
  localparam logic SPASREG_SU   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spasreg_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module : spasreg_wr_arb_if
// Brief  : Requester handshakes plus flop-bank q/d bundle for the arbiter.
// Rev    : 1.0
// ============================================================================
interface spasreg_wr_arb_if #(
  parameter int WIDTH = 32
) ();

  logic             host_req;
  logic [1:0]       host_op;
  logic [WIDTH-1:0] host_data;
  logic             host_ack;
  logic             su_req;
  logic [1:0]       su_op;
  logic [WIDTH-1:0] su_data;
  logic             su_ack;
  logic             freeze;
  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  logic             reg_wr;
  logic             reg_src;
  logic             host_pend;
  logic             su_pend;

  modport master (
    output host_req, host_op, host_data, su_req, su_op, su_data, freeze, reg_q,
    input  host_ack, su_ack, reg_d, reg_wr, reg_src, host_pend, su_pend
  );

  modport slave (
    input  host_req, host_op, host_data, su_req, su_op, su_data, freeze, reg_q,
    output host_ack, su_ack, reg_d, reg_wr, reg_src, host_pend, su_pend
  );

endinterface
`default_nettype wire

// File: rtl/spasreg_slot.sv
`default_nettype none
// ============================================================================
// Module : spasreg_slot
// Brief  : One-entry command buffer with ack-gated capture and pop on commit.
// Rev    : 1.0
// ============================================================================
module spasreg_slot
  import spasreg_pkg::*;
#(
  parameter int WIDTH = SPASREG_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             reset_l,
  input  wire logic             i_req,
  input  wire logic [1:0]       i_op,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output      logic             o_ack,
  output      logic             o_full,
  output      spasreg_op_e      o_op,
  output      logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic             r_ack;
  spasreg_op_e      r_op;
  logic [WIDTH-1:0] r_data;
  logic             w_capture;

  // A req still high during its own ack cycle is the old command; ignore it.
  assign w_capture = i_req & ~r_full & ~r_ack;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_full <= 1'b0;
      r_ack  <= 1'b0;
      r_op   <= SPASREG_OP_WRITE;
      r_data <= '0;
    end else begin
      r_ack <= w_capture;
      if (w_capture) begin
        r_full <= 1'b1;
        r_op   <= spasreg_op_e'(i_op);
        r_data <= i_data;
      end else if (i_pop) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_ack  = r_ack;
  assign o_full = r_full;
  assign o_op   = r_op;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/spasreg_wr_arb.sv
`default_nettype none
// ============================================================================
// Module : spasreg_wr_arb
// Brief  : Round-robin write arbiter and RMW sequencer for a flop-bank
//          control register shared by host and su requesters.
// Rev    : 1.0
// ============================================================================
module spasreg_wr_arb
  import spasreg_pkg::*;
#(
  parameter int WIDTH = SPASREG_WIDTH
) (
  input wire logic        clk,
  input wire logic        reset_l,
  spasreg_wr_arb_if.slave bus
);

  logic             w_host_full;
  logic             w_host_ack;
  spasreg_op_e      w_host_op;
  logic [WIDTH-1:0] w_host_data;
  logic             w_su_full;
  logic             w_su_ack;
  spasreg_op_e      w_su_op;
  logic [WIDTH-1:0] w_su_data;

  logic             w_grant_host;
  logic             w_grant_su;
  logic             w_commit;
  logic             w_src;
  spasreg_op_e      w_sel_op;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_rmw;

  logic             r_rr_ptr;
  logic             r_src;

  spasreg_slot #(.WIDTH(WIDTH)) u_host_slot (
    .clk     (clk),
    .reset_l (reset_l),
    .i_req   (bus.host_req),
    .i_op    (bus.host_op),
    .i_data  (bus.host_data),
    .i_pop   (w_grant_host),
    .o_ack   (w_host_ack),
    .o_full  (w_host_full),
    .o_op    (w_host_op),
    .o_data  (w_host_data)
  );

  spasreg_slot #(.WIDTH(WIDTH)) u_su_slot (
    .clk     (clk),
    .reset_l (reset_l),
    .i_req   (bus.su_req),
    .i_op    (bus.su_op),
    .i_data  (bus.su_data),
    .i_pop   (w_grant_su),
    .o_ack   (w_su_ack),
    .o_full  (w_su_full),
    .o_op    (w_su_op),
    .o_data  (w_su_data)
  );

  // rr_ptr only matters when both slots are full.
  always_comb begin
    w_grant_host = 1'b0;
    w_grant_su   = 1'b0;
    if (!bus.freeze) begin
      if (w_host_full && (!w_su_full || !r_rr_ptr)) begin
        w_grant_host = 1'b1;
      end else if (w_su_full) begin
        w_grant_su = 1'b1;
      end
    end
  end

  assign w_commit   = w_grant_host | w_grant_su;
  assign w_src      = w_grant_su ? SPASREG_SU : SPASREG_HOST;
  assign w_sel_op   = w_grant_su ? w_su_op   : w_host_op;
  assign w_sel_data = w_grant_su ? w_su_data : w_host_data;

  always_comb begin
    w_rmw = bus.reg_q;
    case (w_sel_op)
      SPASREG_OP_WRITE:  w_rmw = w_sel_data;
      SPASREG_OP_SET:    w_rmw = bus.reg_q | w_sel_data;
      SPASREG_OP_CLR:    w_rmw = bus.reg_q & ~w_sel_data;
      SPASREG_OP_TOGGLE: w_rmw = bus.reg_q ^ w_sel_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_rr_ptr <= 1'b0;
      r_src    <= SPASREG_HOST;
    end else if (w_commit) begin
      r_rr_ptr <= w_grant_host;
      r_src    <= w_src;
    end
  end

  // The bank has no load enable, so d must recirculate q when idle.
  assign bus.reg_d     = w_commit ? w_rmw : bus.reg_q;
  assign bus.reg_wr    = w_commit;
  assign bus.reg_src   = w_commit ? w_src : r_src;
  assign bus.host_ack  = w_host_ack;
  assign bus.su_ack    = w_su_ack;
  assign bus.host_pend = w_host_full;
  assign bus.su_pend   = w_su_full;

endmodule
`default_nettype wire

// File: tb/tb_spasreg_wr_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_spasreg_wr_arb
// Brief  : Directed self-checking bench; models the flop bank behind reg_q.
// Rev    : 1.0
// ============================================================================
module tb_spasreg_wr_arb;

  logic        clk;
  logic        reset_l;
  logic [31:0] r_bank;
  int          n_cmp;
  int          n_err;

  spasreg_wr_arb_if #(.WIDTH(32)) bus ();

  spasreg_wr_arb #(.WIDTH(32)) u_dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_bank <= '0;
    else          r_bank <= bus.reg_d;
  end
  assign bus.reg_q = r_bank;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_l = 1'b0;
    bus.host_req = 1'b0; bus.host_op = 2'b00; bus.host_data = '0;
    bus.su_req = 1'b0;   bus.su_op = 2'b00;   bus.su_data = '0;
    bus.freeze = 1'b0;
    tick(); tick();
    reset_l = 1'b1;
    #1;
    check_eq("rst_host_ack", bus.host_ack, 0);
    check_eq("rst_su_ack", bus.su_ack, 0);
    check_eq("rst_pend", {bus.host_pend, bus.su_pend}, 0);
    check_eq("rst_wr", bus.reg_wr, 0);
    check_eq("rst_src", bus.reg_src, 0);
    check_eq("rst_d", bus.reg_d, 0);

    // Host WRITE latency
    bus.host_req = 1'b1; bus.host_op = 2'b00; bus.host_data = 32'hDEADBEEF;
    tick();
    check_eq("w_ack", bus.host_ack, 1);
    check_eq("w_wr", bus.reg_wr, 1);
    check_eq("w_src", bus.reg_src, 0);
    check_eq("w_d", bus.reg_d, 32'hDEADBEEF);
    bus.host_req = 1'b0;
    tick();
    check_eq("w_q", bus.reg_q, 32'hDEADBEEF);
    check_eq("w_ack_drop", bus.host_ack, 0);
    check_eq("w_wr_drop", bus.reg_wr, 0);
    check_eq("w_pend_drop", bus.host_pend, 0);

    // Preload 0x0000FF00 then su SET / CLR
    bus.host_req = 1'b1; bus.host_data = 32'h0000FF00;
    tick();
    bus.host_req = 1'b0;
    tick();
    check_eq("pre_q", bus.reg_q, 32'h0000FF00);
    bus.su_req = 1'b1; bus.su_op = 2'b01; bus.su_data = 32'h000000F0;
    tick();
    check_eq("set_ack", bus.su_ack, 1);
    check_eq("set_src", bus.reg_src, 1);
    check_eq("set_d", bus.reg_d, 32'h0000FFF0);
    bus.su_op = 2'b10; bus.su_data = 32'h00000F00;
    tick();
    check_eq("set_q", bus.reg_q, 32'h0000FFF0);
    check_eq("clr_gated_ack", bus.su_ack, 0);
    check_eq("clr_gated_wr", bus.reg_wr, 0);
    tick();
    check_eq("clr_ack", bus.su_ack, 1);
    check_eq("clr_d", bus.reg_d, 32'h0000F0F0);
    bus.su_req = 1'b0;
    tick();
    check_eq("clr_q", bus.reg_q, 32'h0000F0F0);

    // Contention from reset
    reset_l = 1'b0;
    tick();
    reset_l = 1'b1;
    bus.host_req = 1'b1; bus.host_op = 2'b00; bus.host_data = 32'h1;
    bus.su_req = 1'b1;   bus.su_op = 2'b11;   bus.su_data = 32'h3;
    tick();
    check_eq("arb_acks", {bus.host_ack, bus.su_ack}, 2'b11);
    check_eq("arb1_src", bus.reg_src, 0);
    check_eq("arb1_d", bus.reg_d, 32'h1);
    bus.host_req = 1'b0; bus.su_req = 1'b0;
    tick();
    check_eq("arb1_q", bus.reg_q, 32'h1);
    check_eq("arb2_wr", bus.reg_wr, 1);
    check_eq("arb2_src", bus.reg_src, 1);
    tick();
    check_eq("arb2_q", bus.reg_q, 32'h2);
    check_eq("idle_src_hold", bus.reg_src, 1);
    check_eq("idle_d", bus.reg_d, 32'h2);
    // host-only commit leaves rr_ptr favouring su for the next conflict
    bus.host_req = 1'b1; bus.host_op = 2'b00; bus.host_data = 32'h10;
    tick();
    bus.host_req = 1'b0;
    tick();
    bus.host_req = 1'b1; bus.host_op = 2'b01; bus.host_data = 32'h100;
    bus.su_req = 1'b1;   bus.su_op = 2'b01;   bus.su_data = 32'h1000;
    tick();
    check_eq("arb3_src", bus.reg_src, 1);
    check_eq("arb3_d", bus.reg_d, 32'h1010);
    bus.host_req = 1'b0; bus.su_req = 1'b0;
    tick();
    check_eq("arb4_src", bus.reg_src, 0);
    check_eq("arb4_d", bus.reg_d, 32'h1110);
    tick();
    check_eq("arb4_q", bus.reg_q, 32'h1110);

    // Freeze with both slots full; su favoured after the last host commit
    bus.freeze = 1'b1;
    bus.host_req = 1'b1; bus.host_op = 2'b01; bus.host_data = 32'h1;
    bus.su_req = 1'b1;   bus.su_op = 2'b10;   bus.su_data = 32'h1000;
    tick();
    check_eq("frz_acks", {bus.host_ack, bus.su_ack}, 2'b11);
    check_eq("frz_wr", bus.reg_wr, 0);
    bus.host_op = 2'b00; bus.host_data = 32'hAAAA;
    bus.su_req = 1'b0;
    tick();
    check_eq("frz_stall_ack", bus.host_ack, 0);
    check_eq("frz_pend", {bus.host_pend, bus.su_pend}, 2'b11);
    tick();
    check_eq("frz_stall_ack2", bus.host_ack, 0);
    check_eq("frz_q", bus.reg_q, 32'h1110);
    check_eq("frz_wr2", bus.reg_wr, 0);
    bus.freeze = 1'b0;
    #1;
    check_eq("thaw1_src", bus.reg_src, 1);
    check_eq("thaw1_d", bus.reg_d, 32'h0110);
    tick();
    check_eq("thaw2_src", bus.reg_src, 0);
    check_eq("thaw2_d", bus.reg_d, 32'h0111);
    check_eq("thaw2_ack", bus.host_ack, 0);
    tick();
    check_eq("thaw2_q", bus.reg_q, 32'h0111);
    check_eq("thaw_empty", {bus.host_pend, bus.host_ack, bus.reg_wr}, 0);
    tick();
    check_eq("recap_ack", bus.host_ack, 1);
    check_eq("recap_d", bus.reg_d, 32'hAAAA);
    bus.host_req = 1'b0;
    tick();
    check_eq("recap_q", bus.reg_q, 32'hAAAA);

    // Asynchronous reset with an su command pending
    bus.freeze = 1'b1;
    bus.su_req = 1'b1; bus.su_op = 2'b01; bus.su_data = 32'hF;
    tick();
    check_eq("ar_pend", bus.su_pend, 1);
    bus.su_req = 1'b0;
    bus.freeze = 1'b0;
    #1;
    check_eq("ar_wr_pre", bus.reg_wr, 1);
    #1;
    reset_l = 1'b0;
    #1;
    check_eq("ar_pend_clr", bus.su_pend, 0);
    check_eq("ar_ack_clr", bus.su_ack, 0);
    check_eq("ar_wr_clr", bus.reg_wr, 0);
    tick();
    reset_l = 1'b1;
    tick();
    check_eq("ar_post_wr", {bus.reg_wr, bus.su_pend}, 0);
    tick();
    check_eq("ar_post_q", bus.reg_q, 0);

    // Held su_req: ack gating allows exactly one further capture
    bus.su_req = 1'b1; bus.su_op = 2'b11; bus.su_data = 32'h55;
    tick();
    check_eq("hold_ack1", bus.su_ack, 1);
    tick();
    check_eq("hold_gap_ack", bus.su_ack, 0);
    check_eq("hold_gap_pend", bus.su_pend, 0);
    check_eq("hold_q1", bus.reg_q, 32'h55);
    tick();
    check_eq("hold_ack2", bus.su_ack, 1);
    bus.su_req = 1'b0;
    tick();
    check_eq("hold_q2", bus.reg_q, 0);
    check_eq("hold_end_ack", bus.su_ack, 0);
    tick();
    check_eq("hold_end_q", bus.reg_q, 0);
    check_eq("hold_end_pend", {bus.su_pend, bus.su_ack}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
